// File: rtl/uart_baud_sampler.sv
// RX front end for uart_rx: synchronises the serial line, derives a 16x oversample
// tick from a fractional phase accumulator and majority-votes three mid-bit samples.
module uart_baud_sampler #(
  parameter int ACC_WIDTH   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ACC_WIDTH-1:0] phase_inc,
  input  logic                 phase_accum_reset,
  input  logic                 rx_pin,
  output logic                 baud_tick,
  output logic                 rx_bit,
  output logic                 noise_error
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] CNT_S7 = 4'd7;
  localparam logic [3:0] CNT_S8 = 4'd8;
  localparam logic [3:0] CNT_S9 = 4'd9;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   carry_q, carry_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             vote_q, vote_d;
  logic                   rx_bit_q, rx_bit_d;
  logic                   baud_tick_q, baud_tick_d;
  logic                   noise_q, noise_d;

  logic                   rx_s;
  logic                   os_tick;
  logic [ACC_WIDTH:0]     sum;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign os_tick = carry_q && (state_q == RUN);
  assign sum     = {1'b0, acc_q} + {1'b0, phase_inc};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_pin};
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = 1'b0;
    cnt_d       = cnt_q;
    vote_d      = vote_q;
    rx_bit_d    = rx_bit_q;
    baud_tick_d = 1'b0;
    noise_d     = 1'b0;

    if (phase_accum_reset) begin
      // Idle: discard any partial vote and pass the line straight through for start detection.
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      vote_d   = 3'b111;
      rx_bit_d = rx_s;
    end else begin
      state_d          = RUN;
      {carry_d, acc_d} = sum;
      if (os_tick) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_S7 || cnt_q == CNT_S8 || cnt_q == CNT_S9) begin
          vote_d = {vote_q[1:0], rx_s};
        end
        if (cnt_q == CNT_S9) begin
          // The third sample is taken live, so the vote completes in the tick cycle.
          rx_bit_d    = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
          baud_tick_d = 1'b1;
          noise_d     = !((vote_q[1] == vote_q[0]) && (vote_q[0] == rx_s));
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the synchroniser and rx_bit reset to 1 (idle line) so reset never looks like a start bit.
      sync_q      <= '1;
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      vote_q      <= 3'b111;
      rx_bit_q    <= 1'b1;
      baud_tick_q <= 1'b0;
      noise_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      vote_q      <= vote_d;
      rx_bit_q    <= rx_bit_d;
      baud_tick_q <= baud_tick_d;
      noise_q     <= noise_d;
    end
  end

  assign baud_tick   = baud_tick_q;
  assign rx_bit      = rx_bit_q;
  assign noise_error = noise_q;

endmodule

// File: tb/tb_uart_baud_sampler.sv
// Directed bench for uart_baud_sampler: reset, tick cadence, noise voting, abort,
// zero/max increment and a full 8N1 frame with the bench acting as uart_rx.
module tb_uart_baud_sampler;

  localparam int AW = 24;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] phase_inc;
  logic          phase_accum_reset;
  logic          rx_pin;
  logic          baud_tick;
  logic          rx_bit;
  logic          noise_error;

  int total = 0;
  int bad   = 0;

  int   edge_n;
  int   viol;
  logic prev_tick;
  int   tick_edge[$];
  logic tick_bit[$];
  logic tick_noise[$];

  uart_baud_sampler #(.ACC_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .phase_inc         (phase_inc),
    .phase_accum_reset (phase_accum_reset),
    .rx_pin            (rx_pin),
    .baud_tick         (baud_tick),
    .rx_bit            (rx_bit),
    .noise_error       (noise_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int edge_at(input int i);
    return (i < tick_edge.size()) ? tick_edge[i] : -1;
  endfunction

  function automatic logic bit_at(input int i);
    return (i < tick_bit.size()) ? tick_bit[i] : 1'bx;
  endfunction

  function automatic logic noise_at(input int i);
    return (i < tick_noise.size()) ? tick_noise[i] : 1'bx;
  endfunction

  // Drops phase_accum_reset; the next rising edge is edge 1 of the run.
  task automatic release_run();
    tick_edge.delete();
    tick_bit.delete();
    tick_noise.delete();
    edge_n            = 0;
    viol              = 0;
    prev_tick         = 1'b0;
    phase_accum_reset = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) begin
      step(1);
      edge_n++;
      if (baud_tick) begin
        tick_edge.push_back(edge_n);
        tick_bit.push_back(rx_bit);
        tick_noise.push_back(noise_error);
        if (prev_tick) viol++;
      end
      if (noise_error && !baud_tick) viol++;
      prev_tick = baud_tick;
    end
  endtask

  task automatic go_idle(input int n);
    phase_accum_reset = 1'b1;
    rx_pin            = 1'b1;
    step(n);
  endtask

  initial begin
    logic [9:0] frame_bits;
    int         n_ticks;
    int         n_noise;
    logic       seen_start;

    // NOTE: inputs are driven with blocking assignments from this process, away from the clock edge.
    reset_n           = 1'b0;
    phase_inc         = AW'(1 << 22);
    phase_accum_reset = 1'b1;
    rx_pin            = 1'b1;
    step(2);
    check("reset_rx_bit", rx_bit, 1'b1);
    check("reset_tick", baud_tick, 1'b0);
    check("reset_noise", noise_error, 1'b0);
    reset_n = 1'b1;
    step(3);

    // Cadence with os_tick every 4 clocks: ticks at 41, then every 64.
    release_run();
    run_to(200);
    check("cad_first", edge_at(0), 41);
    check("cad_second", edge_at(1), 105);
    check("cad_third", edge_at(2), 169);
    check("cad_count", tick_edge.size(), 3);
    check("cad_width_viol", viol, 0);

    // Async reset while a tick with rx_bit=0 is being presented.
    go_idle(2);
    rx_pin = 1'b0;
    step(3);
    release_run();
    run_to(41);
    check("pre_rst_tick", baud_tick, 1'b1);
    check("pre_rst_bit", rx_bit, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_bit", rx_bit, 1'b1);
    check("async_rst_tick", baud_tick, 1'b0);
    check("async_rst_noise", noise_error, 1'b0);
    phase_accum_reset = 1'b1;
    reset_n           = 1'b1;
    step(SS);
    check("idle_lat_early", rx_bit, 1'b1);
    step(1);
    check("idle_lat_exact", rx_bit, 1'b0);
    go_idle(4);

    // Noise: bit 0 samples 7,8,9 use the pin at edges 31,35,39; bit 1 at 95,99,103.
    release_run();
    run_to(33);
    rx_pin = 1'b0;
    run_to(36);
    rx_pin = 1'b1;
    run_to(93);
    rx_pin = 1'b0;
    run_to(100);
    rx_pin = 1'b1;
    run_to(180);
    check("noise8_edge", edge_at(0), 41);
    check("noise8_bit", bit_at(0), 1'b1);
    check("noise8_flag", noise_at(0), 1'b1);
    check("noise78_bit", bit_at(1), 1'b0);
    check("noise78_flag", noise_at(1), 1'b1);
    check("clean_bit", bit_at(2), 1'b1);
    check("clean_flag", noise_at(2), 1'b0);
    check("noise_viol", viol, 0);
    go_idle(4);

    // Abort at cnt 8 of bit 3 (that os_tick lands on edge 229).
    release_run();
    run_to(228);
    check("abort_pre_cnt", dut.cnt_q, 8);
    phase_accum_reset = 1'b1;
    run_to(229);
    check("abort_acc", dut.acc_q, 0);
    check("abort_cnt", dut.cnt_q, 0);
    run_to(320);
    check("abort_ticks", tick_edge.size(), 3);
    rx_pin = 1'b0;
    step(SS + 1);
    check("abort_follow0", rx_bit, 1'b0);
    rx_pin = 1'b1;
    step(SS);
    check("abort_follow_hold", rx_bit, 1'b0);
    step(1);
    check("abort_follow1", rx_bit, 1'b1);
    release_run();
    run_to(45);
    check("rerelease_first", edge_at(0), 41);
    go_idle(4);

    // Zero increment never ticks and holds rx_bit.
    phase_inc = '0;
    release_run();
    run_to(1000);
    check("zero_ticks", tick_edge.size(), 0);
    check("zero_hold", rx_bit, 1'b1);
    go_idle(2);

    // Maximum increment; a one-clock release advances acc once and is then cleared.
    phase_inc = '1;
    phase_accum_reset = 1'b0;
    step(1);
    phase_accum_reset = 1'b1;
    check("pulse_acc_once", dut.acc_q, 32'h00FF_FFFF);
    check("pulse_no_tick", baud_tick, 1'b0);
    step(1);
    check("pulse_acc_clear", dut.acc_q, 0);
    check("pulse_no_tick2", baud_tick, 1'b0);
    // Carry first appears at edge 2 and is registered, so the 10th os_tick is used at edge 12.
    release_run();
    run_to(60);
    check("max_first", edge_at(0), 12);
    check("max_second", edge_at(1), 28);
    check("max_count", tick_edge.size(), 4);
    check("max_viol", viol, 0);
    go_idle(4);

    // 0x5A 8N1 at 115200 baud / 100 MHz, bench releases one clock after the start edge.
    phase_inc  = AW'(309238);
    frame_bits = '0;
    n_ticks    = 0;
    n_noise    = 0;
    seen_start = 1'b0;
    fork
      begin
        logic [9:0] line;
        line = {1'b1, 8'h5A, 1'b0};
        for (int b = 0; b < 10; b++) begin
          rx_pin = line[b];
          step(868);
        end
        rx_pin = 1'b1;
      end
      begin
        for (int i = 0; i < 2000 && !seen_start; i++) begin
          step(1);
          if (rx_bit == 1'b0) seen_start = 1'b1;
        end
        if (seen_start) begin
          step(1);
          phase_accum_reset = 1'b0;
          for (int i = 0; i < 12000 && n_ticks < 10; i++) begin
            step(1);
            if (noise_error) n_noise++;
            if (baud_tick) begin
              frame_bits[n_ticks] = rx_bit;
              n_ticks++;
            end
          end
        end
        phase_accum_reset = 1'b1;
      end
    join
    check("frame_start_seen", seen_start, 1'b1);
    check("frame_ticks", n_ticks, 10);
    check("frame_bits", frame_bits, 10'h2B4);
    check("frame_byte", frame_bits[8:1], 8'h5A);
    check("frame_noise", n_noise, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
